// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each granted request is evaluated the same cycle and its result, source
// port, tag and illegal-code flag are queued in a small response FIFO.
module alu_arbiter #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  resp_data,
    output logic              resp_src,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err
);

    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             src;
        logic [TAG_W-1:0] tag;
        logic             err;
    } resp_t;

    resp_t             mem_q [RESP_DEPTH];
    resp_t             head;
    resp_t             push_entry;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rr_q;
    logic [WIDTH-1:0]  last_a_q, last_b_q;
    logic [CTRL_W-1:0] last_ctrl_q;
    logic              space, grant0, grant1, push, pop, legal;

    // Grant: single requester wins outright, contention resolved by rr pointer.
    // Nothing is readied while reset is asserted.
    always_comb begin
        pop    = resp_valid & resp_ready;
        space  = rst_n & ((count_q < CNT_W'(RESP_DEPTH)) | pop);
        grant0 = space & req0_valid & (~req1_valid | ~rr_q);
        grant1 = space & req1_valid & (~req0_valid | rr_q);
        push   = grant0 | grant1;
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Operand mux; ALU inputs hold their last value when nothing is granted.
    always_comb begin
        alu_a    = last_a_q;
        alu_b    = last_b_q;
        alu_ctrl = last_ctrl_q;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    // Legal-code decode and the entry to be queued on a handshake.
    always_comb begin
        legal = (alu_ctrl == CTRL_W'(4'b0000)) | (alu_ctrl == CTRL_W'(4'b0001)) |
                (alu_ctrl == CTRL_W'(4'b0010)) | (alu_ctrl == CTRL_W'(4'b0011)) |
                (alu_ctrl == CTRL_W'(4'b0100)) | (alu_ctrl == CTRL_W'(4'b0110));
        push_entry.data = legal ? alu_result : '0;
        push_entry.src  = grant1;
        push_entry.tag  = grant1 ? req1_tag : req0_tag;
        push_entry.err  = ~legal;
    end

    // Occupancy next-state from push/pop.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state: pointers, count, rr pointer and held ALU operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rr_q        <= 1'b0;
            last_a_q    <= '0;
            last_b_q    <= '0;
            last_ctrl_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                rr_q        <= grant0;
                last_a_q    <= alu_a;
                last_b_q    <= alu_b;
                last_ctrl_q <= alu_ctrl;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage; stale contents are masked by resp_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head outputs, forced to zero while the FIFO is empty.
    always_comb begin
        resp_valid = (count_q != '0);
        head       = resp_valid ? mem_q[rd_ptr_q] : '0;
        resp_data  = head.data;
        resp_src   = head.src;
        resp_tag   = head.tag;
        resp_err   = head.err;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SHL = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_BAD = 4'b0111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req0_tag, req1_ctrl, req1_tag;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        resp_valid, resp_ready, resp_src, resp_err;
    logic [63:0] resp_data;
    logic [3:0]  resp_tag;

    int n_vec  = 0;
    int n_miss = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .req1_tag   (req1_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_src   (resp_src),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; illegal codes return a nonzero junk value.
    always_comb begin
        case (alu_ctrl)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SHL:  alu_result = alu_a << alu_b[5:0];
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            default: alu_result = 64'hDEAD;
        endcase
    end

    typedef struct {
        logic        v0;
        logic [3:0]  c0;
        logic [63:0] a0, b0;
        logic [3:0]  t0;
        logic        v1;
        logic [3:0]  c1;
        logic [63:0] a1, b1;
        logic [3:0]  t1;
        logic        rr;
        logic        e_r0, e_r1, e_rv;
        logic [63:0] e_data;
        logic        e_src;
        logic [3:0]  e_tag;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic v0, input logic [3:0] c0, input logic [63:0] a0, input logic [63:0] b0,
        input logic [3:0] t0,
        input logic v1, input logic [3:0] c1, input logic [63:0] a1, input logic [63:0] b1,
        input logic [3:0] t1,
        input logic rr, input logic e_r0, input logic e_r1, input logic e_rv,
        input logic [63:0] e_data, input logic e_src, input logic [3:0] e_tag,
        input logic e_err);
        vec_t v;
        v.v0 = v0; v.c0 = c0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
        v.v1 = v1; v.c1 = c1; v.a1 = a1; v.b1 = b1; v.t1 = t1;
        v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rv = e_rv;
        v.e_data = e_data; v.e_src = e_src; v.e_tag = e_tag; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; req1_tag = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        req0_valid = v.v0; req0_ctrl = v.c0; req0_a = v.a0; req0_b = v.b0; req0_tag = v.t0;
        req1_valid = v.v1; req1_ctrl = v.c1; req1_a = v.a1; req1_b = v.b1; req1_tag = v.t1;
        resp_ready = v.rr;
        #1;
        chk($sformatf("v%0d req0_ready", idx), 64'(req0_ready), 64'(v.e_r0));
        chk($sformatf("v%0d req1_ready", idx), 64'(req1_ready), 64'(v.e_r1));
        if (v.e_r0) chk($sformatf("v%0d alu_a", idx), alu_a, v.a0);
        if (v.e_r1) chk($sformatf("v%0d alu_a", idx), alu_a, v.a1);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d resp_valid", idx), 64'(resp_valid), 64'(v.e_rv));
        if (v.e_rv) begin
            chk($sformatf("v%0d resp_data", idx), resp_data, v.e_data);
            chk($sformatf("v%0d resp_src", idx), 64'(resp_src), 64'(v.e_src));
            chk($sformatf("v%0d resp_tag", idx), 64'(resp_tag), 64'(v.e_tag));
            chk($sformatf("v%0d resp_err", idx), 64'(resp_err), 64'(v.e_err));
        end
    endtask

    initial begin
        //            v0 c0      a0     b0    t0  v1 c1      a1     b1    t1  rr r0 r1 rv data  src tag err
        vecs.push_back(mk(1, OP_ADD, 5,     7,    3,  0, 0,      0,     0,    0,  1, 1, 0, 1, 12,   0, 3, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  0, 0,      0,     0,    0,  1, 0, 0, 0, 0,    0, 0, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  1, OP_ADD, 1,     2,    5,  1, 0, 1, 1, 3,    1, 5, 0));
        vecs.push_back(mk(1, OP_SUB, 10,    4,    1,  1, OP_XOR, 'hF0,  'h0F, 2,  1, 1, 0, 1, 6,    0, 1, 0));
        vecs.push_back(mk(1, OP_SUB, 10,    4,    1,  1, OP_XOR, 'hF0,  'h0F, 2,  1, 0, 1, 1, 'hFF, 1, 2, 0));
        vecs.push_back(mk(1, OP_SUB, 10,    4,    1,  1, OP_XOR, 'hF0,  'h0F, 2,  1, 1, 0, 1, 6,    0, 1, 0));
        vecs.push_back(mk(1, OP_SUB, 10,    4,    1,  1, OP_XOR, 'hF0,  'h0F, 2,  1, 0, 1, 1, 'hFF, 1, 2, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  0, 0,      0,     0,    0,  1, 0, 0, 0, 0,    0, 0, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  1, OP_OR,  3,     4,    7,  1, 0, 1, 1, 7,    1, 7, 0));
        vecs.push_back(mk(1, OP_AND, 'hC,   'hA,  8,  1, OP_ADD, 1,     1,    9,  1, 1, 0, 1, 8,    0, 8, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  1, OP_ADD, 1,     1,    9,  1, 0, 1, 1, 2,    1, 9, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  0, 0,      0,     0,    0,  1, 0, 0, 0, 0,    0, 0, 0));
        vecs.push_back(mk(1, OP_BAD, 1,     1,    4,  0, 0,      0,     0,    0,  1, 1, 0, 1, 0,    0, 4, 1));
        vecs.push_back(mk(1, OP_ADD, 2,     3,    5,  0, 0,      0,     0,    0,  1, 1, 0, 1, 5,    0, 5, 0));
        vecs.push_back(mk(1, OP_SHL, 1,     4,    6,  0, 0,      0,     0,    0,  1, 1, 0, 1, 16,   0, 6, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  0, 0,      0,     0,    0,  1, 0, 0, 0, 0,    0, 0, 0));
        // Backpressure: two fit, the third waits and enters on the pop cycle.
        vecs.push_back(mk(0, 0,      0,     0,    0,  1, OP_ADD, 1,     0,    1,  0, 0, 1, 1, 1,    1, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  1, OP_ADD, 2,     0,    2,  0, 0, 1, 1, 1,    1, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  1, OP_ADD, 3,     0,    3,  0, 0, 0, 1, 1,    1, 1, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  1, OP_ADD, 3,     0,    3,  1, 0, 1, 1, 2,    1, 2, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  0, 0,      0,     0,    0,  1, 0, 0, 1, 3,    1, 3, 0));
        vecs.push_back(mk(0, 0,      0,     0,    0,  0, 0,      0,     0,    0,  1, 0, 0, 0, 0,    0, 0, 0));

        // Reset state, with a request pending that must not be readied.
        rst_n = 1'b0;
        resp_ready = 1'b1;
        drive_idle();
        req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_ctrl = OP_ADD;
        #12;
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset req0_ready", 64'(req0_ready), 64'd0);
        chk("reset resp_data", resp_data, 64'd0);
        chk("reset alu_a", alu_a, 64'd0);
        chk("reset alu_ctrl", 64'(alu_ctrl), 64'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // ALU operands hold the last granted request while idle.
        chk("hold alu_a", alu_a, 64'd3);
        chk("hold alu_b", alu_b, 64'd0);
        chk("hold alu_ctrl", 64'(alu_ctrl), 64'(OP_ADD));

        // Fill the FIFO, then reset asynchronously mid-cycle.
        @(negedge clk);
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_ctrl = OP_ADD; req0_a = 64'd1; req0_b = 64'd1; req0_tag = 4'd1;
        @(negedge clk);
        req0_a = 64'd2; req0_b = 64'd2; req0_tag = 4'd2;
        @(negedge clk);
        drive_idle();
        #1;
        chk("full resp_valid", 64'(resp_valid), 64'd1);
        chk("full resp_data", resp_data, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst resp_valid", 64'(resp_valid), 64'd0);
        chk("async rst resp_data", resp_data, 64'd0);
        req0_valid = 1'b1; req0_ctrl = OP_AND; req0_a = 64'hF; req0_b = 64'h3; req0_tag = 4'hA;
        req1_valid = 1'b1; req1_ctrl = OP_ADD; req1_a = 64'd1; req1_b = 64'd1; req1_tag = 4'hB;
        resp_ready = 1'b1;
        #1;
        chk("in rst req0_ready", 64'(req0_ready), 64'd0);
        chk("in rst req1_ready", 64'(req1_ready), 64'd0);
        chk("in rst alu_a", alu_a, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst req0_ready", 64'(req0_ready), 64'd1);
        chk("post rst req1_ready", 64'(req1_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("post rst resp_valid", 64'(resp_valid), 64'd1);
        chk("post rst resp_data", resp_data, 64'd3);
        chk("post rst resp_src", 64'(resp_src), 64'd0);
        chk("post rst resp_tag", 64'(resp_tag), 64'hA);
        @(negedge clk);
        drive_idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
